// File: rtl/rts_dcts_input_buffer.sv
// Receive side of the RTS/DCTS link: grants DCTS only when buffer space
// exists, stores one flit per handshake and exposes the FIFO head as valid/ready.
//
// state | meaning
// IDLE  | waiting for RTS with space available
// GRANT | DCTS high; transfer if RTS still high
module rts_dcts_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   rx,
    input  logic                    RTS,
    output logic                    DCTS,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fill_count,
    output logic                    proto_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           fill_q, fill_d;
    logic                    proto_q, proto_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    wr_en;
    logic                    rd_en;

    always_comb begin
        wr_en   = (state_q == GRANT) && RTS;
        rd_en   = (fill_q != '0) && out_ready;

        // Space check uses the count before any same-cycle pop.
        state_d = IDLE;
        if ((state_q == IDLE) && RTS && (fill_q < FULL_C)) begin
            state_d = GRANT;
        end

        proto_d  = proto_q | ((state_q == GRANT) && !RTS);
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;

        fill_d = fill_q;
        case ({wr_en, rd_en})
            2'b10:   fill_d = fill_q + CW'(1);
            2'b01:   fill_d = fill_q - CW'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            proto_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            proto_q  <= proto_d;
        end
    end

    // Storage is deliberately not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rx;
        end
    end

    assign DCTS       = (state_q == GRANT);
    assign out_valid  = (fill_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign fill_count = fill_q;
    assign proto_err  = proto_q;
endmodule

// File: tb/tb_rts_dcts_input_buffer.sv
// Randomized bench for rts_dcts_input_buffer: an upstream driver, a random
// consumer, and a queue-based reference model checked every cycle.
module tb_rts_dcts_input_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx;
    logic          RTS;
    logic          DCTS;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fill_count;
    logic          proto_err;

    int total = 0;
    int bad = 0;
    int delivered = 0;
    int popped = 0;
    bit rand_ready_on = 0;

    // reference state
    logic [DW-1:0] m_q[$];
    bit m_grant = 0;
    bit m_proto = 0;

    rts_dcts_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .RTS(RTS), .DCTS(DCTS),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fill_count(fill_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT against model, then advance the model for the next edge.
    initial begin
        bit pop, wr, grant_next;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("dcts", DW'(DCTS), DW'(m_grant));
            chk("fill_count", DW'(fill_count), DW'(m_q.size()));
            chk("out_valid", DW'(out_valid), DW'(m_q.size() != 0));
            chk("proto_err", DW'(proto_err), DW'(m_proto));
            if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);

            pop = out_ready && (m_q.size() != 0);
            wr = m_grant && RTS;
            if (m_grant && !RTS) m_proto = 1;
            grant_next = !m_grant && RTS && (m_q.size() < DEPTH);
            if (pop) begin
                void'(m_q.pop_front());
                popped++;
            end
            if (wr) m_q.push_back(rx);
            m_grant = grant_next;
            if (rst) begin
                m_q.delete();
                m_grant = 0;
                m_proto = 0;
            end
        end
    end

    // Random consumer while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_on) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Upstream: raise RTS with stable data, hold until DCTS seen, drop for one cycle.
    task automatic send(input logic [DW-1:0] d);
        int n;
        RTS = 1'b1;
        rx = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!DCTS && n < 200);
        total++;
        if (!DCTS) begin
            bad++;
            $display("FAIL send_timeout data %h: no DCTS within %0d cycles", d, n);
        end else begin
            delivered++;
        end
        @(posedge clk);
        #1;
        RTS = 1'b0;
        rx = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (m_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        step(2);
        chk("drain_empty", DW'(m_q.size()), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        RTS = 1'b0;
        rx = '0;
        out_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);

        // single flit
        send(32'hA5A5_0001);
        step(2);
        drain();

        // fill to full, stall fifth flit, release with one pop
        for (int i = 1; i <= 4; i++) send(DW'(i));
        fork
            send(32'h5);
        join_none
        step(10);
        chk("full_no_dcts", DW'(DCTS), 0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        wait fork;
        drain();

        // streaming with consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h100 + DW'(i));
        drain();

        // random traffic with random consumer
        rand_ready_on = 1;
        for (int i = 0; i < 40; i++) begin
            send($urandom);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 4));
        end
        rand_ready_on = 0;
        drain();

        // RTS dropped during the DCTS cycle
        RTS = 1'b1;
        rx = 32'hDEAD_BEEF;
        step(1);
        RTS = 1'b0;
        step(4);
        chk("proto_sticky", DW'(proto_err), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);

        // reset during DCTS with three flits buffered
        for (int i = 0; i < 3; i++) send(32'h300 + DW'(i));
        RTS = 1'b1;
        rx = 32'h3FF;
        step(1);
        rst = 1'b1;
        RTS = 1'b0;
        step(1);
        rst = 1'b0;
        delivered -= 3;
        step(3);
        chk("post_rst_fill", DW'(fill_count), 0);

        send(32'hCAFE_0001);
        drain();
        chk("popped_count", DW'(popped), DW'(delivered));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
